result_ram: RTL and testbench

- Write-side counterpart of the matrix operand ROM.
- Accepts packed blocks of BLOCK_SIZE result words from the systolic array output stage and stores them at consecutive addresses from a self-managed write pointer.
- Provides a single-word registered read port for the controller and testbench readback.
- Signals full/done when MEM_DEPTH words have been captured.

---
 rtl/result_ram_if.sv | 34 +++
 rtl/result_ram.sv | 96 +++++++++
 tb/tb_result_ram.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/result_ram_if.sv
// Bundle for the result RAM: block write handshake, single-word read port and fill status.
// Write handshake: a block transfers on the rising edge where wr_valid && wr_ready; wr_data only matters then.
interface result_ram_if #(
  parameter int DATA_WIDTH = 16,
  parameter int MEM_DEPTH  = 9,
  parameter int BLOCK_SIZE = 3
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(MEM_DEPTH + 1);

  logic                             clear;
  logic                             wr_valid;
  logic                             wr_ready;
  logic [BLOCK_SIZE*DATA_WIDTH-1:0] wr_data;
  logic                             rd_en;
  logic [AW-1:0]                    rd_addr;
  logic [DATA_WIDTH-1:0]            rd_data;
  logic                             rd_valid;
  logic [CW-1:0]                    wr_count;
  logic                             full;
  logic                             done;
  logic                             err;
  logic                             state_dbg;

  modport master (
    output clear, wr_valid, wr_data, rd_en, rd_addr,
    input  wr_ready, rd_data, rd_valid, wr_count, full, done, err, state_dbg
  );

  modport slave (
    input  clear, wr_valid, wr_data, rd_en, rd_addr,
    output wr_ready, rd_data, rd_valid, wr_count, full, done, err, state_dbg
  );
endinterface

// File: rtl/result_ram.sv
// Result RAM: captures packed result blocks at a self-managed write pointer until MEM_DEPTH
// words are stored, with a registered single-word read port usable in any state.
module result_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int MEM_DEPTH  = 9,
  parameter int BLOCK_SIZE = 3
) (
  input  logic        clk,
  input  logic        reset,
  result_ram_if.slave bus
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(MEM_DEPTH + 1);

  typedef enum logic {S_FILL = 1'b0, S_FULL = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  wr_en;

  logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];

  // clear has priority over an incoming block, which is then dropped
  assign wr_en = reset && !bus.clear && bus.wr_valid && (state_q == S_FILL);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    if (bus.clear) begin
      state_d = S_FILL;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else if (bus.wr_valid) begin
      if (state_q == S_FILL) begin
        if (int'(cnt_q) + BLOCK_SIZE >= MEM_DEPTH) begin
          cnt_d   = CW'(MEM_DEPTH);
          state_d = S_FULL;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(BLOCK_SIZE);
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (int'(bus.rd_addr) < MEM_DEPTH) rd_word = mem[bus.rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_FILL;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rd_data_q <= rd_word;
    end
  end

  // No reset on the array; words past the last address of a partial block are discarded
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        if (int'(cnt_q) + i < MEM_DEPTH)
          mem[AW'(int'(cnt_q) + i)] <= bus.wr_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.wr_ready  = (state_q == S_FILL);
  assign bus.full      = (state_q == S_FULL);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.wr_count  = cnt_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_result_ram.sv
// Bench for result_ram: directed plan plus randomized traffic against a word-array model (depth 9),
// and a directed partial-block run on a depth-8 instance.
module tb_result_ram;
  logic clk;
  logic reset;

  result_ram_if #(.DATA_WIDTH(16), .MEM_DEPTH(9), .BLOCK_SIZE(3)) bus9 ();
  result_ram_if #(.DATA_WIDTH(16), .MEM_DEPTH(8), .BLOCK_SIZE(3)) bus8 ();

  result_ram #(.DATA_WIDTH(16), .MEM_DEPTH(9), .BLOCK_SIZE(3)) u_dut9 (
    .clk(clk), .reset(reset), .bus(bus9.slave));
  result_ram #(.DATA_WIDTH(16), .MEM_DEPTH(8), .BLOCK_SIZE(3)) u_dut8 (
    .clk(clk), .reset(reset), .bus(bus8.slave));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model for the depth-9 instance
  logic [15:0] m_mem [9];
  int          m_cnt;
  bit          m_err, m_done, m_rd_valid;
  logic [15:0] m_rd_data;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // one clock on the depth-9 instance, model update, full output comparison
  task automatic step(input bit rst_n, input bit clr, input bit wv, input logic [47:0] wd,
                      input bit re, input logic [3:0] ra);
    logic [15:0] exp_rd;
    reset         = rst_n;
    bus9.clear    = clr;
    bus9.wr_valid = wv;
    bus9.wr_data  = wd;
    bus9.rd_en    = re;
    bus9.rd_addr  = ra;
    if (!rst_n) begin
      m_cnt = 0; m_err = 0; m_done = 0; m_rd_valid = 0; m_rd_data = '0;
    end else begin
      if (re) begin
        m_rd_valid = 1;
        m_rd_data  = (ra < 9) ? m_mem[ra] : 16'h0;
        exp_q.push_back(m_rd_data);
      end else begin
        m_rd_valid = 0;
      end
      m_done = 0;
      if (clr) begin
        m_cnt = 0; m_err = 0;
      end else if (wv) begin
        if (m_cnt < 9) begin
          for (int i = 0; i < 3; i++)
            if (m_cnt + i < 9) m_mem[m_cnt + i] = wd[i*16 +: 16];
          m_cnt  = (m_cnt + 3 > 9) ? 9 : m_cnt + 3;
          m_done = (m_cnt == 9);
        end else begin
          m_err = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    check("wr_count", 64'(bus9.wr_count), 64'(m_cnt));
    check("full",     64'(bus9.full),     64'(m_cnt == 9));
    check("wr_ready", 64'(bus9.wr_ready), 64'(m_cnt < 9));
    check("done",     64'(bus9.done),     64'(m_done));
    check("err",      64'(bus9.err),      64'(m_err));
    check("rd_valid", 64'(bus9.rd_valid), 64'(m_rd_valid));
    if (m_rd_valid) begin
      exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      check("rd_data", 64'(bus9.rd_data), 64'(exp_rd));
    end else begin
      check("rd_hold", 64'(bus9.rd_data), 64'(m_rd_data));
    end
  endtask

  task automatic idle9();
    step(1, 0, 0, 48'h0, 0, 4'h0);
  endtask

  task automatic blk9(input logic [47:0] wd);
    step(1, 0, 1, wd, 0, 4'h0);
  endtask

  task automatic rd9(input logic [3:0] ra);
    step(1, 0, 0, 48'h0, 1, ra);
  endtask

  task automatic step8(input bit wv, input logic [47:0] wd, input bit re, input logic [2:0] ra);
    bus8.wr_valid = wv;
    bus8.wr_data  = wd;
    bus8.rd_en    = re;
    bus8.rd_addr  = ra;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus8.clear = 0; bus8.wr_valid = 0; bus8.wr_data = '0; bus8.rd_en = 0; bus8.rd_addr = '0;
    for (int i = 0; i < 9; i++) m_mem[i] = 'x;
    m_rd_data = '0;

    step(0, 0, 0, 48'h0, 0, 4'h0);
    check("rst_state", 64'(bus9.state_dbg), 64'(0));
    idle9();

    // partial final block on the depth-8 instance
    step8(1, {16'h0013, 16'h0012, 16'h0011}, 0, 3'd0);
    step8(1, {16'h0023, 16'h0022, 16'h0021}, 0, 3'd0);
    check("d8_cnt6", 64'(bus8.wr_count), 64'(6));
    step8(1, {16'h0033, 16'h0032, 16'h0031}, 0, 3'd0);
    check("d8_cnt8", 64'(bus8.wr_count), 64'(8));
    check("d8_full", 64'(bus8.full), 64'(1));
    check("d8_done", 64'(bus8.done), 64'(1));
    step8(0, 48'h0, 1, 3'd6);
    check("d8_done_off", 64'(bus8.done), 64'(0));
    check("d8_rd6", 64'(bus8.rd_data), 64'(16'h0031));
    check("d8_rv6", 64'(bus8.rd_valid), 64'(1));
    step8(0, 48'h0, 1, 3'd7);
    check("d8_rd7", 64'(bus8.rd_data), 64'(16'h0032));
    step8(0, 48'h0, 1, 3'd2);
    check("d8_rd2", 64'(bus8.rd_data), 64'(16'h0013));
    step8(0, 48'h0, 0, 3'd0);
    check("d8_rv_off", 64'(bus8.rd_valid), 64'(0));

    // fill the depth-9 instance with 1..9
    blk9({16'h0003, 16'h0002, 16'h0001});
    check("cnt_3", 64'(bus9.wr_count), 64'(3));
    blk9({16'h0006, 16'h0005, 16'h0004});
    check("cnt_6", 64'(bus9.wr_count), 64'(6));
    blk9({16'h0009, 16'h0008, 16'h0007});
    check("cnt_9", 64'(bus9.wr_count), 64'(9));
    check("done_pulse", 64'(bus9.done), 64'(1));
    for (int a = 0; a < 9; a++) begin
      rd9(4'(a));
      check("rd_fill", 64'(bus9.rd_data), 64'(a + 1));
    end
    check("done_once", 64'(bus9.done), 64'(0));
    rd9(4'd12);
    check("rd_oob", 64'(bus9.rd_data), 64'(0));

    // write while full
    blk9({16'hFFFF, 16'hFFFF, 16'hFFFF});
    check("err_set", 64'(bus9.err), 64'(1));
    idle9(); idle9();
    rd9(4'd0);
    check("full_rd0", 64'(bus9.rd_data), 64'(1));
    check("err_held", 64'(bus9.err), 64'(1));

    // clear racing a block
    step(1, 1, 0, 48'h0, 0, 4'h0);
    blk9({16'h000C, 16'h000B, 16'h000A});
    step(1, 1, 1, {16'h00EE, 16'h00EE, 16'h00EE}, 0, 4'h0);
    check("clr_cnt", 64'(bus9.wr_count), 64'(0));
    check("clr_state", 64'(bus9.state_dbg), 64'(0));
    blk9({16'h000F, 16'h000E, 16'h000D});
    rd9(4'd0);
    check("clr_rd0", 64'(bus9.rd_data), 64'(16'h000D));

    // read/write collision at addr 4
    step(1, 0, 1, {16'h0066, 16'h00AA, 16'h0044}, 1, 4'd4);
    check("coll_old", 64'(bus9.rd_data), 64'(16'h0005));
    rd9(4'd4);
    check("coll_new", 64'(bus9.rd_data), 64'(16'h00AA));

    // reset mid-fill with a read pending
    step(1, 1, 0, 48'h0, 0, 4'h0);
    blk9({16'h0103, 16'h0102, 16'h0101});
    blk9({16'h0106, 16'h0105, 16'h0104});
    step(0, 0, 0, 48'h0, 1, 4'd0);
    check("rst_rv", 64'(bus9.rd_valid), 64'(0));
    check("rst_rd", 64'(bus9.rd_data), 64'(0));
    check("rst_cnt", 64'(bus9.wr_count), 64'(0));
    rd9(4'd0);
    check("rst_keep", 64'(bus9.rd_data), 64'(16'h0101));

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 1) == 1), {16'($urandom), 16'($urandom), 16'($urandom)},
           ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
